// File: rtl/abr_ram_rd_streamer_pkg.sv
// Shared types and constants for the RAM read streamer and its output buffer.
package abr_ram_rd_streamer_pkg;

   // Sequencer states. The debug port carries this enum so checkers can
   // bind to readable names.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_strm_state_e;

   // Raw encodings used by the FSM registers.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Output buffer entries. Together with the single in-flight read this
   // bounds outstanding reads.
   localparam int BUF_DEPTH = 2;

   // Credits that will still be in use at the next edge:
   // buffered words plus the read in flight, minus the word leaving now.
   // A pop implies occ >= 1, so the result never underflows.
   function automatic logic [2:0] credits_used(input logic [1:0] occ,
                                               input logic       inflight,
                                               input logic       pop);
      return 3'(occ) + 3'(inflight) - 3'(pop);
   endfunction

endpackage

// File: rtl/abr_ram_rd_streamer_fifo2.sv
// Two-entry register FIFO with a data word and a last tag per entry.
// The head entry sits in its own register, so the stream outputs come
// straight from flops. The head changes only on a pop or on a push into an
// empty buffer. Push and pop may happen in the same cycle at any occupancy.
module abr_fifo2
   import abr_ram_rd_streamer_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_b,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         push_last_i,
   input  logic         pop_i,
   output logic [W-1:0] head_data_o,
   output logic         head_last_o,
   output logic [1:0]   occ_o
);

   logic [W-1:0] head_data_q, head_data_d;
   logic         head_last_q, head_last_d;
   logic [W-1:0] tail_data_q, tail_data_d;
   logic         tail_last_q, tail_last_d;
   logic [1:0]   occ_q, occ_d;

   // Next-state of the two entries and the occupancy count.
   always_comb begin
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      occ_d       = occ_q;
      if (clr_i) begin
         head_data_d = '0;
         head_last_d = 1'b0;
         tail_data_d = '0;
         tail_last_d = 1'b0;
         occ_d       = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  head_data_d = push_data_i;
                  head_last_d = push_last_i;
                  occ_d       = 2'd1;
               end else if (occ_q == 2'd1) begin
                  tail_data_d = push_data_i;
                  tail_last_d = push_last_i;
                  occ_d       = 2'd2;
               end
            end
            2'b01: begin
               if (occ_q == 2'd2) begin
                  head_data_d = tail_data_q;
                  head_last_d = tail_last_q;
                  occ_d       = 2'd1;
               end else if (occ_q == 2'd1) begin
                  // Buffer empties: drop the tag so last_o does not linger.
                  head_last_d = 1'b0;
                  occ_d       = 2'd0;
               end
            end
            2'b11: begin
               if (occ_q == 2'd2) begin
                  head_data_d = tail_data_q;
                  head_last_d = tail_last_q;
                  tail_data_d = push_data_i;
                  tail_last_d = push_last_i;
               end else begin
                  // At occupancy 1 the new word replaces the departing head.
                  // At occupancy 0 the pop is not real, so this is a plain push.
                  head_data_d = push_data_i;
                  head_last_d = push_last_i;
                  occ_d       = 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         occ_q       <= occ_d;
      end
   end

   assign head_data_o = head_data_q;
   assign head_last_o = head_last_q;
   assign occ_o       = occ_q;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_b)
      !(push_i && !pop_i && !clr_i && (occ_q == 2'(BUF_DEPTH))));

endmodule

// File: rtl/abr_ram_rd_streamer.sv
// Read-side sequencer for a 1R1W RAM with a registered read port.
// A burst of len_i words starting at base_addr_i (wrapping at DEPTH) is
// issued to the RAM and streamed out with full backpressure.
//
// Handshake: a word transfers on every rising edge where valid_o and
// ready_i are both high. While valid_o is high and ready_i is low, data_o
// and last_o hold their values. valid_o never depends on ready_i.
module abr_ram_rd_streamer
   import abr_ram_rd_streamer_pkg::*;
#(
   parameter  int DEPTH      = 64,
   parameter  int DATA_WIDTH = 32,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_b,
   input  logic                  zeroize_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  re_o,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output rd_strm_state_e        dbg_state_o
);

   localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   remain_q, remain_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;

   logic [1:0]            occ;
   logic                  head_last;
   logic                  pop;
   logic                  issue;
   logic                  issue_last;
   logic [ADDR_WIDTH-1:0] rd_ptr_inc;

   // Stream side: valid whenever the buffer holds a word.
   assign valid_o = (occ != 2'd0);
   assign pop     = valid_o & ready_i;
   assign last_o  = head_last;

   // Credit check: issue only if the new read still fits in the buffer
   // once the words already buffered or in flight have landed.
   assign issue      = (state_q == ST_RUN) && (credits_used(occ, inflight_q, pop) < 3'(BUF_DEPTH));
   assign issue_last = issue && (remain_q == LEN_ONE);
   assign rd_ptr_inc = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);

   // Sequencer FSM, address pointer, remaining count and in-flight tracking.
   always_comb begin
      state_d         = state_q;
      rd_ptr_d        = rd_ptr_q;
      remain_d        = remain_q;
      inflight_d      = issue;
      inflight_last_d = issue_last;
      if (zeroize_i) begin
         state_d         = ST_IDLE;
         rd_ptr_d        = '0;
         remain_d        = '0;
         inflight_d      = 1'b0;
         inflight_last_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  rd_ptr_d = base_addr_i;
                  remain_d = len_i;
                  state_d  = (len_i == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  rd_ptr_d = rd_ptr_inc;
                  remain_d = remain_q - LEN_ONE;
                  if (issue_last) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && head_last) state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
         state_q         <= ST_IDLE;
         rd_ptr_q        <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_ptr_q        <= rd_ptr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // Returning read data is captured only when a read is actually in
   // flight. A read abandoned by zeroize lands with inflight_q already clear.
   abr_fifo2 #(.W(DATA_WIDTH)) u_buf (
      .clk_i       (clk_i),
      .rst_b       (rst_b),
      .clr_i       (zeroize_i),
      .push_i      (inflight_q),
      .push_data_i (rdata_i),
      .push_last_i (inflight_last_q),
      .pop_i       (pop),
      .head_data_o (data_o),
      .head_last_o (head_last),
      .occ_o       (occ)
   );

   assign re_o        = issue;
   assign raddr_o     = rd_ptr_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign dbg_state_o = rd_strm_state_e'(state_q);

   a_re_only_run: assert property (@(posedge clk_i) disable iff (!rst_b)
      re_o |-> (state_q == ST_RUN));

   a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_b)
      (valid_o && !ready_i && !zeroize_i) |=> ($stable(data_o) && $stable(last_o)));

   a_len_legal: assert property (@(posedge clk_i) disable iff (!rst_b)
      (state_q == ST_IDLE && start_i && !zeroize_i) |-> (len_i <= LEN_MAX));

endmodule

// File: tb/tb_abr_ram_rd_streamer.sv
// Directed bench for abr_ram_rd_streamer with a behavioural registered-read
// RAM holding RAM[i] = i * 0x01010101.
module tb_abr_ram_rd_streamer;

  localparam int DEPTH = 64;
  localparam logic [31:0] K = 32'h01010101;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        zeroize_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  base_addr_i = '0;
  logic [6:0]  len_i = '0;
  logic        busy_o, done_o, re_o, valid_o, last_o;
  logic [5:0]  raddr_o;
  logic [31:0] rdata_i = '0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  abr_ram_rd_streamer_pkg::rd_strm_state_e dbg_state_o;

  logic [31:0] mem [DEPTH];
  logic [31:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset / RAM model
  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) * K;

  always @(posedge clk) if (re_o) rdata_i <= mem[raddr_o];

  abr_ram_rd_streamer #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_b       (rst_b),
    .zeroize_i   (zeroize_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .re_o        (re_o),
    .raddr_o     (raddr_o),
    .rdata_i     (rdata_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .dbg_state_o (dbg_state_o)
  );

  // Drives a start; returns 1 ns into cycle 1 (cycle 0 = edge sampling start).
  task automatic start_burst(input logic [5:0] base, input logic [6:0] len);
    base_addr_i = base;
    len_i = len;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_cmp++; if (re_o !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b expected 0", re_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", last_o); end
    n_cmp++; if (raddr_o !== 6'd0) begin n_err++; $display("FAIL reset_raddr: got %0d expected 0", raddr_o); end
    n_cmp++; if (data_o !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", data_o); end
    n_cmp++; if (dbg_state_o !== abr_ram_rd_streamer_pkg::IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
    rst_b = 1'b1;
    @(posedge clk); #2;
  endtask

  // base=4, len=8, ready=1: exact cycle timing.
  task automatic test_basic();
    logic [31:0] exp_d;
    ready_i = 1'b1;
    start_burst(6'd4, 7'd8);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      #1;
      n_cmp++; if (valid_o !== (cyc >= 3 && cyc <= 10)) begin n_err++; $display("FAIL basic_valid c%0d: got %b", cyc, valid_o); end
      if (cyc >= 3 && cyc <= 10) begin
        exp_d = 32'(4 + cyc - 3) * K;
        n_cmp++; if (data_o !== exp_d) begin n_err++; $display("FAIL basic_data c%0d: got %h expected %h", cyc, data_o, exp_d); end
        n_cmp++; if (last_o !== (cyc == 10)) begin n_err++; $display("FAIL basic_last c%0d: got %b", cyc, last_o); end
      end
      n_cmp++; if (re_o !== (cyc <= 8)) begin n_err++; $display("FAIL basic_re c%0d: got %b", cyc, re_o); end
      if (cyc <= 8) begin
        n_cmp++; if (raddr_o !== 6'(4 + cyc - 1)) begin n_err++; $display("FAIL basic_raddr c%0d: got %0d expected %0d", cyc, raddr_o, 4 + cyc - 1); end
      end
      n_cmp++; if (done_o !== (cyc == 11)) begin n_err++; $display("FAIL basic_done c%0d: got %b", cyc, done_o); end
      n_cmp++; if (busy_o !== (cyc <= 11)) begin n_err++; $display("FAIL basic_busy c%0d: got %b", cyc, busy_o); end
    end
  endtask

  // base=DEPTH-2, len=4: address wrap.
  task automatic test_wrap();
    logic [5:0]  got_addr [$];
    logic [5:0]  exp_addr [4];
    logic [31:0] exp_d;
    int          n_done;
    exp_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
    n_done = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(exp_addr[i]) * K);
    ready_i = 1'b1;
    start_burst(6'd62, 7'd4);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      #1;
      if (re_o) got_addr.push_back(raddr_o);
      if (done_o) n_done++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL wrap_extra: got %h expected none", data_o);
        end else begin
          exp_d = exp_q.pop_front();
          n_cmp++; if (data_o !== exp_d) begin n_err++; $display("FAIL wrap_data: got %h expected %h", data_o, exp_d); end
          n_cmp++; if (last_o !== (exp_q.size() == 0)) begin n_err++; $display("FAIL wrap_last: got %b expected %b", last_o, exp_q.size() == 0); end
        end
      end
    end
    n_cmp++; if (got_addr.size() != 4) begin n_err++; $display("FAIL wrap_nreads: got %0d expected 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      n_cmp++; if (got_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, got_addr[i], exp_addr[i]); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_missing: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL wrap_done: got %0d pulses expected 1", n_done); end
  endtask

  // len=8 with random 30% ready: order, completeness, outstanding-read bound.
  task automatic test_backpressure();
    logic [31:0] exp_d;
    int          outstanding;
    bit          done_seen;
    outstanding = 0;
    done_seen = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(30 + i) * K);
    ready_i = 1'b0;
    start_burst(6'd30, 7'd8);
    for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      ready_i = ($urandom_range(0, 9) < 3);
      #1;
      n_cmp++; if (outstanding > 2) begin n_err++; $display("FAIL bp_credit c%0d: got %0d outstanding expected <=2", cyc, outstanding); end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL bp_extra: got %h expected none", data_o);
        end else begin
          exp_d = exp_q.pop_front();
          n_cmp++; if (data_o !== exp_d) begin n_err++; $display("FAIL bp_data: got %h expected %h", data_o, exp_d); end
          n_cmp++; if (last_o !== (exp_q.size() == 0)) begin n_err++; $display("FAIL bp_last: got %b expected %b", last_o, exp_q.size() == 0); end
        end
        outstanding--;
      end
      if (re_o) outstanding++;
      if (done_o) done_seen = 1'b1;
    end
    n_cmp++; if (!done_seen) begin n_err++; $display("FAIL bp_timeout: got no done expected done"); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); end
    ready_i = 1'b1;
    @(posedge clk); #2;
  endtask

  // len=0: done at cycle 1, no reads, no data.
  task automatic test_len_zero();
    ready_i = 1'b1;
    start_burst(6'd5, 7'd0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      #1;
      n_cmp++; if (done_o !== (cyc == 1)) begin n_err++; $display("FAIL len0_done c%0d: got %b", cyc, done_o); end
      n_cmp++; if (busy_o !== (cyc == 1)) begin n_err++; $display("FAIL len0_busy c%0d: got %b", cyc, busy_o); end
      n_cmp++; if (re_o !== 1'b0) begin n_err++; $display("FAIL len0_re c%0d: got %b expected 0", cyc, re_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL len0_valid c%0d: got %b expected 0", cyc, valid_o); end
    end
  endtask

  // len=DEPTH from base 10 with ready=1; a second start mid-burst is ignored.
  task automatic test_full_depth();
    logic [5:0]  a;
    logic [31:0] exp_d;
    ready_i = 1'b1;
    start_burst(6'd10, 7'd64);
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (cyc == 6) start_i = 1'b0;
      #1;
      n_cmp++; if (valid_o !== (cyc >= 3 && cyc <= 66)) begin n_err++; $display("FAIL full_valid c%0d: got %b", cyc, valid_o); end
      if (cyc >= 3 && cyc <= 66) begin
        a = 6'(10 + cyc - 3);
        exp_d = 32'(a) * K;
        n_cmp++; if (data_o !== exp_d) begin n_err++; $display("FAIL full_data c%0d: got %h expected %h", cyc, data_o, exp_d); end
        n_cmp++; if (last_o !== (cyc == 66)) begin n_err++; $display("FAIL full_last c%0d: got %b", cyc, last_o); end
      end
      n_cmp++; if (done_o !== (cyc == 67)) begin n_err++; $display("FAIL full_done c%0d: got %b", cyc, done_o); end
      if (cyc == 5) begin
        base_addr_i = 6'd0;
        len_i = 7'd5;
        start_i = 1'b1;
      end
    end
  endtask

  // Abort a burst at word 3 with rst_b (use_zero=0) or zeroize_i (use_zero=1),
  // then check a fresh burst.
  task automatic test_abort(input bit use_zero, input logic [5:0] new_base);
    logic [31:0] exp_d;
    int          n_done;
    bit          done_seen;
    n_done = 0;
    done_seen = 1'b0;
    ready_i = 1'b1;
    start_burst(6'd0, 7'd8);
    for (int cyc = 2; cyc <= 6; cyc++) begin @(posedge clk); #1; end
    #1;
    // cycle 6: word 3 on the stream, next read in flight
    n_cmp++; if (re_o !== 1'b1 || valid_o !== 1'b1) begin n_err++; $display("FAIL abort%0d_pre: got re=%b valid=%b expected 1 1", use_zero, re_o, valid_o); end
    n_cmp++; if (data_o !== 32'd3 * K) begin n_err++; $display("FAIL abort%0d_word3: got %h expected %h", use_zero, data_o, 32'd3 * K); end
    if (use_zero) zeroize_i = 1'b1;
    else rst_b = 1'b0;
    @(posedge clk); #1;
    zeroize_i = 1'b0;
    #1;
    n_cmp++; if ({busy_o, done_o, re_o, valid_o, last_o} !== 5'b0) begin n_err++; $display("FAIL abort%0d_ctrl: got %b expected 00000", use_zero, {busy_o, done_o, re_o, valid_o, last_o}); end
    n_cmp++; if (raddr_o !== 6'd0) begin n_err++; $display("FAIL abort%0d_raddr: got %0d expected 0", use_zero, raddr_o); end
    n_cmp++; if (data_o !== 32'd0) begin n_err++; $display("FAIL abort%0d_data: got %h expected 0", use_zero, data_o); end
    rst_b = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #2;
      n_cmp++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin n_err++; $display("FAIL abort%0d_quiet: got done=%b valid=%b expected 0 0", use_zero, done_o, valid_o); end
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(new_base + 6'(i)) * K);
    #1;
    start_burst(new_base, 7'd3);
    for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      #1;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL abort%0d_extra: got %h expected none", use_zero, data_o);
        end else begin
          exp_d = exp_q.pop_front();
          n_cmp++; if (data_o !== exp_d) begin n_err++; $display("FAIL abort%0d_data_after: got %h expected %h", use_zero, data_o, exp_d); end
        end
      end
      if (done_o) begin done_seen = 1'b1; n_done++; end
    end
    n_cmp++; if (!done_seen) begin n_err++; $display("FAIL abort%0d_timeout: got no done expected done", use_zero); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort%0d_missing: got %0d left expected 0", use_zero, exp_q.size()); end
    @(posedge clk); #2;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_full_depth();
    test_abort(1'b0, 6'd20);
    test_abort(1'b1, 6'd40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

endmodule
